// File: rtl/hive_reg_lcd_rx_pkg.sv
// hive_reg_lcd_rx_pkg: shared constants and types for the LCD receive block.
package hive_reg_lcd_rx_pkg;
    localparam int LCD_NIB_W = 4;
    localparam int LCD_RX_FIFO_ADDR_W = 4;
    localparam logic [7:0] RBUS_LCD_RX = 8'h2c;
    localparam int EMPTY_OFS = 1;
    localparam int OVF_OFS = 2;
    localparam int ERR_OFS = 3;
    typedef enum logic {PH_HI, PH_LO} phase_e;
    typedef struct packed {
        logic                 rs;
        logic [LCD_NIB_W-1:0] hi;
        logic [LCD_NIB_W-1:0] lo;
    } lcd_rx_word_t;
endpackage

// File: rtl/hive_reg_lcd_rx_phy.sv
// hive_reg_lcd_rx_phy: synchronizes the LCD bus, detects E falls and pairs nibbles into words.
// LCD_RX_TIMEOUT_EN adds a watchdog that abandons a half-received pair.
module hive_reg_lcd_rx_phy
    import hive_reg_lcd_rx_pkg::*;
#(
    parameter int LCD_W       = LCD_NIB_W,
    parameter int SYNC_W      = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             lcd_rs_i,
    input  logic [LCD_W-1:0] lcd_data_i,
    input  logic             lcd_e_i,
    output logic             push_o,
    output lcd_rx_word_t     word_o,
    output logic             err_o
);
    logic [SYNC_W-1:0] e_q, rs_q;
    logic [SYNC_W-1:0][LCD_W-1:0] d_q;
    logic e_p_q, rs_p_q, rs_hi_q;
    logic [LCD_W-1:0] d_p_q, nib_hi_q;
    phase_e phase_q;
    logic fall, match, timeout;
    // rs/data come from the sample before the fall, while E was still high
    assign fall = e_p_q & ~e_q[SYNC_W-1];
    assign match = rs_p_q == rs_hi_q;
    assign push_o = fall & (phase_q == PH_LO) & match;
    assign err_o = (fall & (phase_q == PH_LO) & ~match) | timeout;
    assign word_o = '{rs: rs_p_q, hi: nib_hi_q, lo: d_p_q};
`ifdef LCD_RX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;
    assign timeout = (phase_q == PH_LO) & ~fall & (cnt_q == CNT_W'(TIMEOUT_CYC));
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || fall || phase_q != PH_LO) cnt_q <= '0;
        else if (cnt_q != CNT_W'(TIMEOUT_CYC)) cnt_q <= cnt_q + 1'b1;
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            e_q      <= '0;
            rs_q     <= '0;
            d_q      <= '0;
            e_p_q    <= 1'b0;
            rs_p_q   <= 1'b0;
            d_p_q    <= '0;
            rs_hi_q  <= 1'b0;
            nib_hi_q <= '0;
            phase_q  <= PH_HI;
        end else begin
            e_q    <= {e_q[SYNC_W-2:0], lcd_e_i};
            rs_q   <= {rs_q[SYNC_W-2:0], lcd_rs_i};
            d_q    <= {d_q[SYNC_W-2:0], lcd_data_i};
            e_p_q  <= e_q[SYNC_W-1];
            rs_p_q <= rs_q[SYNC_W-1];
            d_p_q  <= d_q[SYNC_W-1];
            if (flush_i || timeout) phase_q <= PH_HI;
            else if (fall) begin
                rs_hi_q  <= rs_p_q;
                nib_hi_q <= d_p_q;
                phase_q  <= (phase_q == PH_LO && match) ? PH_HI : PH_LO;
            end
        end
    end
endmodule

// File: rtl/hive_reg_lcd_rx.sv
// hive_reg_lcd_rx: LCD bus responder buffering received {rs, byte} words behind one rbus register.
// Define LCD_RX_TIMEOUT_EN to abandon a pair whose low nibble never arrives.
module hive_reg_lcd_rx
    import hive_reg_lcd_rx_pkg::*;
#(
    parameter int                     ALU_W       = 32,
    parameter int                     RBUS_ADDR_W = 8,
    parameter logic [RBUS_ADDR_W-1:0] ADDR        = RBUS_LCD_RX,
    parameter int                     LCD_W       = LCD_NIB_W,
    parameter int                     FIFO_ADDR_W = LCD_RX_FIFO_ADDR_W,
    parameter int                     SYNC_W      = 2,
    parameter int                     TIMEOUT_CYC = 4096
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [RBUS_ADDR_W-1:0] rbus_addr_i,
    input  logic                   rbus_wr_i,
    input  logic                   rbus_rd_i,
    input  logic [ALU_W-1:0]       rbus_wr_data_i,
    output logic [ALU_W-1:0]       rbus_rd_data_o,
    input  logic                   lcd_rs_i,
    input  logic [LCD_W-1:0]       lcd_data_i,
    input  logic                   lcd_e_i
);
    localparam int FIFO_W = 1 + 2 * LCD_W;
    localparam int DEPTH = 1 << FIFO_ADDR_W;
    logic [FIFO_W-1:0] mem_q [DEPTH];
    logic [FIFO_ADDR_W:0] wr_ptr_q, rd_ptr_q;
    logic ovf_q, err_q;
    logic [ALU_W-1:0] rd_data_q, rd_data_d;
    logic sel, rd_en, clr, flush, empty, full, pop, push, push_ok, phy_err;
    lcd_rx_word_t word;
    logic unused_wr;
    assign unused_wr = ^rbus_wr_data_i[ALU_W-1:2];
    assign sel = rbus_addr_i == ADDR;
    assign rd_en = sel & rbus_rd_i;
    assign clr = sel & rbus_wr_i & rbus_wr_data_i[0];
    assign flush = sel & rbus_wr_i & rbus_wr_data_i[1];
    assign empty = wr_ptr_q == rd_ptr_q;
    assign full = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {FIFO_ADDR_W{1'b0}}};
    assign pop = rd_en & ~empty;
    // a simultaneous pop frees the slot, so a full FIFO still accepts the push
    assign push_ok = push & ~flush & (~full | pop);
    assign rbus_rd_data_o = rd_data_q;
    hive_reg_lcd_rx_phy #(
        .LCD_W      (LCD_W),
        .SYNC_W     (SYNC_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_phy (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .flush_i   (flush),
        .lcd_rs_i  (lcd_rs_i),
        .lcd_data_i(lcd_data_i),
        .lcd_e_i   (lcd_e_i),
        .push_o    (push),
        .word_o    (word),
        .err_o     (phy_err)
    );
    always_comb begin
        rd_data_d = '0;
        rd_data_d[ALU_W-EMPTY_OFS] = empty;
        rd_data_d[ALU_W-OVF_OFS] = ovf_q;
        rd_data_d[ALU_W-ERR_OFS] = err_q;
        rd_data_d[FIFO_W-1:0] = empty ? '0 : mem_q[rd_ptr_q[FIFO_ADDR_W-1:0]];
        rd_data_d = rd_en ? rd_data_d : '0;
    end
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q[FIFO_ADDR_W-1:0]] <= word;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
            wr_ptr_q  <= flush ? '0 : wr_ptr_q + {{FIFO_ADDR_W{1'b0}}, push_ok};
            rd_ptr_q  <= flush ? '0 : rd_ptr_q + {{FIFO_ADDR_W{1'b0}}, pop};
            ovf_q     <= (ovf_q & ~clr) | (push & full & ~pop & ~flush);
            err_q     <= (err_q & ~clr) | phy_err;
        end
    end
endmodule
